skip_sequencer: RTL and testbench

- Sequences the CHIP-8 conditional-skip instructions (3XNN, 4XNN, 5XY0, 9XY0, EX9E, EXA1) around the external 8-bit equality comparator.
- Fetches Vx/Vy from the register file over a req/ack handshake, then drives comparator operands.
- Returns a one-cycle skip decision to the PC/fetch unit.
- Sits between the instruction decoder, the register file, the keypad latch and the comparator.

---
 rtl/skip_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_skip_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/skip_sequencer.sv
// Sequencer for the CHIP-8 conditional-skip instructions (3XNN, 4XNN, 5XY0, 9XY0, EX9E, EXA1).
// Optional build macro STRICT_DECODE_EN: 5XY?/9XY? with a nonzero low nibble decode as illegal.
module skip_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] opcode,
  output logic        busy,
  output logic        done,
  output logic        skip,
  output logic        illegal,
  output logic        timeout,
  output logic        reg_rd_req,
  output logic [3:0]  reg_rd_addr,
  input  logic        reg_rd_ack,
  input  logic [7:0]  reg_rd_data,
  input  logic [15:0] key_state,
  output logic [7:0]  cmp_a,
  output logic [7:0]  cmp_b,
  input  logic        cmp_eq
);

  typedef enum logic [2:0] {IDLE, DECODE, RD_X, RD_Y, CMP, DONE} state_t;

`ifdef STRICT_DECODE_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  // Last wait count before a read is abandoned.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] op_q;
  logic [7:0]  vx;
  logic [7:0]  wait_cnt;

  logic legal;
  logic two_read;
  logic is_key;
  logic invert;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    legal    = 1'b0;
    two_read = 1'b0;
    is_key   = 1'b0;
    invert   = 1'b0;
    case (op_q[15:12])
      4'h3: legal = 1'b1;
      4'h4: begin
        legal  = 1'b1;
        invert = 1'b1;
      end
      4'h5: begin
        legal    = !STRICT || (op_q[3:0] == 4'h0);
        two_read = 1'b1;
      end
      4'h9: begin
        legal    = !STRICT || (op_q[3:0] == 4'h0);
        two_read = 1'b1;
        invert   = 1'b1;
      end
      4'hE: begin
        if (op_q[7:0] == 8'h9E) begin
          legal  = 1'b1;
          is_key = 1'b1;
        end else if (op_q[7:0] == 8'hA1) begin
          legal  = 1'b1;
          is_key = 1'b1;
          invert = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= '0;
      vx          <= '0;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      skip        <= 1'b0;
      illegal     <= 1'b0;
      timeout     <= 1'b0;
      reg_rd_req  <= 1'b0;
      reg_rd_addr <= '0;
      cmp_a       <= '0;
      cmp_b       <= '0;
    end else begin
      // Result flags are pulses that live only in the done cycle.
      done    <= 1'b0;
      skip    <= 1'b0;
      illegal <= 1'b0;
      timeout <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= opcode;
            busy  <= 1'b1;
            state <= DECODE;
          end
        end

        DECODE: begin
          if (legal) begin
            reg_rd_req  <= 1'b1;
            reg_rd_addr <= op_q[11:8];
            wait_cnt    <= '0;
            state       <= RD_X;
          end else begin
            done    <= 1'b1;
            illegal <= 1'b1;
            state   <= DONE;
          end
        end

        RD_X: begin
          if (reg_rd_ack) begin
            vx <= reg_rd_data;
            if (two_read) begin
              reg_rd_addr <= op_q[7:4];
              wait_cnt    <= '0;
              state       <= RD_Y;
            end else begin
              reg_rd_req <= 1'b0;
              if (is_key) begin
                cmp_a <= {7'b0, key_state[reg_rd_data[3:0]]};
                cmp_b <= 8'h01;
              end else begin
                cmp_a <= reg_rd_data;
                cmp_b <= op_q[7:0];
              end
              state <= CMP;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            reg_rd_req <= 1'b0;
            done       <= 1'b1;
            timeout    <= 1'b1;
            state      <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        RD_Y: begin
          // cmp_b doubles as the Vy latch.
          if (reg_rd_ack) begin
            reg_rd_req <= 1'b0;
            cmp_a      <= vx;
            cmp_b      <= reg_rd_data;
            state      <= CMP;
          end else if (wait_cnt == LAST_WAIT) begin
            reg_rd_req <= 1'b0;
            done       <= 1'b1;
            timeout    <= 1'b1;
            state      <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        CMP: begin
          skip  <= cmp_eq ^ invert;
          done  <= 1'b1;
          state <= DONE;
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skip_sequencer.sv
// Directed self-checking bench for skip_sequencer with a register-file responder
// and a behavioural equality comparator.
module tb_skip_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] opcode = '0;
  logic        busy, done, skip, illegal, timeout;
  logic        reg_rd_req;
  logic [3:0]  reg_rd_addr;
  logic        reg_rd_ack = 1'b0;
  logic [7:0]  reg_rd_data = '0;
  logic [15:0] key_state = '0;
  logic [7:0]  cmp_a, cmp_b;
  logic        cmp_eq;

  int tests = 0;
  int fails = 0;

  // Responder controls
  logic [7:0] regs [16];
  int         ack_delay = 0;
  int         no_ack_addr = 99;
  logic       force_ack = 1'b0;
  int         wcnt = 0;
  logic [3:0] reads[$];

  // Per-run results
  int   done_cycle, req_cycles;
  logic d_skip, d_ill, d_to, d_req, flag_err, post_busy, post_done;

  skip_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .busy(busy), .done(done), .skip(skip), .illegal(illegal), .timeout(timeout),
    .reg_rd_req(reg_rd_req), .reg_rd_addr(reg_rd_addr), .reg_rd_ack(reg_rd_ack),
    .reg_rd_data(reg_rd_data), .key_state(key_state),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_eq(cmp_eq)
  );

  always #5 clk = ~clk;

  assign cmp_eq = (cmp_a == cmp_b);

  always @(negedge clk) begin
    if (reg_rd_req && (int'(reg_rd_addr) != no_ack_addr)) begin
      if (wcnt == ack_delay) begin
        reg_rd_ack  = 1'b1;
        reg_rd_data = regs[reg_rd_addr];
        wcnt        = 0;
        reads.push_back(reg_rd_addr);
      end else begin
        reg_rd_ack = 1'b0;
        wcnt++;
      end
    end else begin
      reg_rd_ack  = force_ack;
      reg_rd_data = 8'hFF;
      wcnt        = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one start; done_cycle counts cycles after the accepting edge (0 = never).
  task automatic run(input logic [15:0] op, input int inj);
    reads.delete();
    req_cycles = 0;
    done_cycle = 0;
    flag_err   = 1'b0;
    d_skip = 1'b0; d_ill = 1'b0; d_to = 1'b0; d_req = 1'b0;
    @(negedge clk);
    opcode = op;
    start  = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      #1;
      if (reg_rd_req) req_cycles++;
      if (!busy) flag_err = 1'b1;
      if (!done && (skip || illegal || timeout)) flag_err = 1'b1;
      if (done) begin
        done_cycle = n;
        d_skip = skip; d_ill = illegal; d_to = timeout; d_req = reg_rd_req;
      end
      @(negedge clk);
      start = (n == inj);
      if (start) opcode = 16'h1234;
      if (done_cycle != 0) break;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    post_busy = busy;
    post_done = done;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (busy) post_busy = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'(i * 3);
    regs[3] = 8'h42;
    regs[1] = 8'h10;
    regs[2] = 8'h11;
    regs[5] = 8'hA7;

    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_req", reg_rd_req, 0);
    check("reset_cmp", {cmp_a, cmp_b}, 0);
    @(negedge clk);
    rst = 1'b0;

    run(16'h3342, 0);
    check("3342_cycle", done_cycle, 4);
    check("3342_skip", d_skip, 1);
    check("3342_flags", {d_ill, d_to}, 0);
    check("3342_cmp", {cmp_a, cmp_b}, 16'h4242);
    check("3342_reads", reads.size(), 1);
    if (reads.size() == 1) check("3342_addr", reads[0], 3);
    check("3342_req_cycles", req_cycles, 1);
    check("3342_flag_err", flag_err, 0);
    check("3342_post", {post_busy, post_done}, 0);

    run(16'h4342, 0);
    check("4342_cycle", done_cycle, 4);
    check("4342_skip", d_skip, 0);

    ack_delay = 2;
    run(16'h9120, 0);
    check("9120_cycle", done_cycle, 9);
    check("9120_skip", d_skip, 1);
    check("9120_reads", reads.size(), 2);
    if (reads.size() == 2) check("9120_addrs", {reads[0], reads[1]}, 8'h12);
    check("9120_cmp", {cmp_a, cmp_b}, 16'h1011);
    check("9120_req_cycles", req_cycles, 6);
    check("9120_flag_err", flag_err, 0);

    run(16'h5120, 0);
    check("5120_d2_cycle", done_cycle, 9);
    check("5120_d2_skip", d_skip, 0);

    ack_delay = 0;
    run(16'h5120, 0);
    check("5120_cycle", done_cycle, 5);
    check("5120_skip", d_skip, 0);

    key_state = 16'h0080;
    run(16'hE59E, 0);
    check("E59E_k_cycle", done_cycle, 4);
    check("E59E_k_skip", d_skip, 1);
    check("E59E_k_cmp", {cmp_a, cmp_b}, 16'h0101);
    run(16'hE5A1, 0);
    check("E5A1_k_skip", d_skip, 0);
    key_state = 16'h0000;
    run(16'hE59E, 0);
    check("E59E_nk_skip", d_skip, 0);
    check("E59E_nk_cmp", {cmp_a, cmp_b}, 16'h0001);
    run(16'hE5A1, 0);
    check("E5A1_nk_skip", d_skip, 1);
    key_state = 16'hFF7F;
    run(16'hE59E, 0);
    check("E59E_other_keys_skip", d_skip, 0);

    run(16'h1234, 0);
    check("1234_cycle", done_cycle, 2);
    check("1234_flags", {d_ill, d_skip, d_to}, 3'b100);
    check("1234_req_cycles", req_cycles, 0);
    run(16'hE5FF, 0);
    check("E5FF_cycle", done_cycle, 2);
    check("E5FF_flags", {d_ill, d_skip, d_to}, 3'b100);
    check("E5FF_req_cycles", req_cycles, 0);

    run(16'h5121, 0);
`ifdef STRICT_DECODE_EN
    check("5121_cycle", done_cycle, 2);
    check("5121_flags", {d_ill, d_skip}, 2'b10);
    check("5121_req_cycles", req_cycles, 0);
`else
    check("5121_cycle", done_cycle, 5);
    check("5121_flags", {d_ill, d_skip}, 2'b00);
    check("5121_req_cycles", req_cycles, 2);
`endif

    // Timeout with a stray start mid-operation
    no_ack_addr = 0;
    run(16'h3042, 3);
    check("to_cycle", done_cycle, 6);
    check("to_flags", {d_to, d_skip, d_ill}, 3'b100);
    check("to_req_cycles", req_cycles, 4);
    check("to_req_at_done", d_req, 0);
    check("to_flag_err", flag_err, 0);
    check("to_post", {post_busy, post_done}, 0);
    no_ack_addr = 99;

    // Start in the done cycle is ignored
    run(16'h3342, 4);
    check("dstart_cycle", done_cycle, 4);
    check("dstart_skip", d_skip, 1);
    check("dstart_post_busy", post_busy, 0);

    // Ack without a request is ignored
    @(negedge clk);
    force_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ack", {busy, done, reg_rd_req}, 0);
    @(negedge clk);
    force_ack = 1'b0;

    // Reset while waiting in RD_Y
    no_ack_addr = 2;
    @(negedge clk);
    opcode = 16'h9120;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rdy_req", {reg_rd_req, reg_rd_addr}, 5'h12);
    check("rdy_cmp_before", {cmp_a, cmp_b}, 16'h4242);
    #2;
    rst = 1'b1;
    #1;
    check("rst_outs", {busy, done, skip, illegal, timeout, reg_rd_req}, 0);
    check("rst_cmp", {cmp_a, cmp_b, 4'(reg_rd_addr)}, 0);
    @(negedge clk);
    rst = 1'b0;
    no_ack_addr = 99;

    run(16'h3342, 0);
    check("after_rst_cycle", done_cycle, 4);
    check("after_rst_skip", d_skip, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
